// File: rtl/mdio_master.sv
// Clause 22 MDIO management initiator.
// Turns one read/write register command into a complete MDC/MDIO frame and reports
// read data plus a no-responder flag when the frame ends.
module mdio_master #(
  parameter int CLK_DIV      = 13,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  state_t      state;
  logic [7:0]  div_cnt;
  logic        high_phase;
  logic [5:0]  bit_cnt;
  logic        write_q;
  logic [31:0] tx_shift;
  logic [15:0] rx_shift;
  logic        err_q;
  logic        mdio_meta;
  logic        mdio_sync;
  logic [31:0] frame;
  logic        active;
  logic        low_end;
  logic        bit_end;

  // Everything after the preamble, MSB first: ST, OP, PHYAD, REGAD, TA, DATA.
  // For reads the TA/DATA slots are never driven, so they are simply filled with ones.
  always_comb begin
    frame = {2'b01,
             cmd_write ? 2'b01 : 2'b10,
             cmd_phy_addr,
             cmd_reg_addr,
             cmd_write ? 2'b10 : 2'b11,
             cmd_write ? cmd_wdata : 16'hFFFF};
  end

  assign active  = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);
  assign low_end = active && !high_phase && (div_cnt == DIV_LAST);
  assign bit_end = active && high_phase && (div_cnt == DIV_LAST);

  // Two-flop synchroniser for the asynchronous MDIO pin; idles high like the pull-up.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      mdio_meta <= 1'b1;
      mdio_sync <= 1'b1;
    end else begin
      mdio_meta <= mdio_i;
      mdio_sync <= mdio_meta;
    end
  end

  // Half-period divider: low half then high half of every bit, held at zero outside a frame.
  always_ff @(posedge clk_50) begin
    if (reset || !active) begin
      div_cnt    <= 8'd0;
      high_phase <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= 8'd0;
      high_phase <= !high_phase;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Frame sequencer: drives MDC and MDIO, samples read data and produces the response.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      bit_cnt   <= 6'd0;
      write_q   <= 1'b0;
      tx_shift  <= 32'h0;
      rx_shift  <= 16'h0;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (low_end) begin
        mdc <= 1'b1;
      end else if (bit_end) begin
        mdc <= 1'b0;
      end
      case (state)
        IDLE: begin
          bit_cnt <= 6'd0;
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            write_q   <= cmd_write;
            err_q     <= 1'b0;
            rx_shift  <= 16'h0;
            mdio_oe   <= 1'b1;
            if (PREAMBLE_LEN == 0) begin
              state    <= HDR;
              mdio_o   <= frame[31];
              tx_shift <= {frame[30:0], 1'b0};
            end else begin
              state    <= PRE;
              mdio_o   <= 1'b1;
              tx_shift <= frame;
            end
          end
        end

        PRE: begin
          if (bit_end) begin
            if (bit_cnt == PRE_LAST) begin
              state    <= HDR;
              bit_cnt  <= 6'd0;
              mdio_o   <= tx_shift[31];
              tx_shift <= {tx_shift[30:0], 1'b0};
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        HDR: begin
          if (bit_end) begin
            mdio_o   <= tx_shift[31];
            tx_shift <= {tx_shift[30:0], 1'b0};
            if (bit_cnt == HDR_LAST) begin
              state   <= TA;
              bit_cnt <= 6'd0;
              mdio_oe <= write_q;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        TA: begin
          if (bit_end) begin
            mdio_o   <= tx_shift[31];
            tx_shift <= {tx_shift[30:0], 1'b0};
            if (bit_cnt == TA_LAST) begin
              state   <= DATA;
              bit_cnt <= 6'd0;
              err_q   <= !write_q && mdio_sync;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        DATA: begin
          if (low_end && !write_q) begin
            rx_shift <= {rx_shift[14:0], mdio_sync};
          end
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              state     <= DONE;
              bit_cnt   <= 6'd0;
              mdio_oe   <= 1'b0;
              mdio_o    <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= write_q ? 16'h0000 : rx_shift;
              rsp_err   <= err_q;
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              mdio_o   <= tx_shift[31];
              tx_shift <= {tx_shift[30:0], 1'b0};
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          mdc       <= 1'b0;
          mdio_o    <= 1'b1;
          mdio_oe   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: directed frames with hand-computed wire images and responses,
// a PHY responder model on the pin, and a scoreboard monitor that checks every response.
module tb_mdio_master;

  localparam int CLK_DIV    = 4;
  localparam int FRAME_CYC  = 64 * 2 * CLK_DIV;
  localparam int FRAME0_CYC = 32 * 2 * CLK_DIV;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cycle;
    logic [63:0] wire_bits;
    logic [63:0] oe_bits;
  } exp_t;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rsp_rdata;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [4:0]  b_cmd_phy_addr, b_cmd_reg_addr;
  logic [15:0] b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_err, b_busy, b_mdc, b_mdio_o, b_mdio_oe, b_mdio_i;
  logic [15:0] b_rsp_rdata;

  logic        phy_mode = 1'b0;
  logic [15:0] phy_data = 16'h0;
  logic        phy_drv_en = 1'b0;
  logic        phy_drv_val = 1'b1;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rises = 0;
  logic        mdc_prev = 1'b0;
  logic [63:0] cap_o = 64'h0;
  logic [63:0] cap_oe = 64'h0;
  exp_t        exp_q[$];
  exp_t        expb_q[$];

  always #10 clk_50 = ~clk_50;

  assign mdio_i   = mdio_oe ? mdio_o : (phy_drv_en ? phy_drv_val : 1'b1);
  assign b_mdio_i = b_mdio_oe ? b_mdio_o : 1'b1;

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(32)) dut (
    .clk_50(clk_50), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(0)) dut_nopre (
    .clk_50(clk_50), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_phy_addr(b_cmd_phy_addr), .cmd_reg_addr(b_cmd_reg_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy),
    .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_oe(b_mdio_oe), .mdio_i(b_mdio_i)
  );

  // Cycle counter; cycle k is the one that starts at the k-th rising edge.
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Wire capture, PHY responder and scoreboard for the preamble-32 instance.
  always @(negedge clk_50) begin
    exp_t e;
    if (reset) begin
      rises       = 0;
      mdc_prev    = 1'b0;
      phy_drv_en  = 1'b0;
      phy_drv_val = 1'b1;
    end else begin
      if (mdc && !mdc_prev) begin
        cap_o  = {cap_o[62:0], mdio_o};
        cap_oe = {cap_oe[62:0], mdio_oe};
        if (phy_mode) begin
          if (rises == 46) begin
            phy_drv_en  = 1'b1;
            phy_drv_val = 1'b0;
          end else if (rises >= 47 && rises <= 62) begin
            phy_drv_en  = 1'b1;
            phy_drv_val = phy_data[62 - rises];
          end else if (rises == 63) begin
            phy_drv_en = 1'b0;
          end
        end
        rises++;
      end
      mdc_prev = mdc;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
          checkOutput("rsp_cycle", 64'(cyc), 64'(e.cycle));
          checkOutput("busy_at_rsp", 64'(busy), 64'd1);
          checkOutput("mdc_rises", 64'(rises), 64'd64);
          checkOutput("wire_bits", cap_o & e.oe_bits, e.wire_bits);
          checkOutput("wire_oe", cap_oe, e.oe_bits);
        end
        rises = 0;
      end
    end
  end

  // Scoreboard for the preamble-suppressed instance.
  always @(negedge clk_50) begin
    exp_t e;
    if (!reset && b_rsp_valid) begin
      if (expb_q.size() == 0) begin
        checkOutput("nopre_unexpected_rsp_valid", 64'(b_rsp_valid), 64'd0);
      end else begin
        e = expb_q.pop_front();
        checkOutput("nopre_rsp_rdata", 64'(b_rsp_rdata), 64'(e.rdata));
        checkOutput("nopre_rsp_err", 64'(b_rsp_err), 64'(e.err));
        checkOutput("nopre_rsp_cycle", 64'(cyc), 64'(e.cycle));
        checkOutput("nopre_busy_at_rsp", 64'(b_busy), 64'd1);
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] wdata, input logic [63:0] wire_exp,
                               input logic [63:0] oe_exp, input logic [15:0] rdata_exp,
                               input logic err_exp, input bit expect_rsp, input bit hold,
                               output int acc);
    exp_t e;
    @(negedge clk_50);
    cmd_valid    = 1'b1;
    cmd_write    = wr;
    cmd_phy_addr = phy;
    cmd_reg_addr = regad;
    cmd_wdata    = wdata;
    acc = -1;
    for (int t = 0; t < 2000; t++) begin
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk_50);
    end
    if (acc < 0) begin
      reportTimeout("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      e.rdata     = rdata_exp;
      e.err       = err_exp;
      e.cycle     = acc + 1 + FRAME_CYC;
      e.wire_bits = wire_exp;
      e.oe_bits   = oe_exp;
      exp_q.push_back(e);
    end
    @(negedge clk_50);
    if (!hold) begin
      cmd_valid    = 1'b0;
      cmd_write    = ~wr;
      cmd_phy_addr = ~phy;
      cmd_reg_addr = ~regad;
      cmd_wdata    = ~wdata;
    end
  endtask

  task automatic applyStimulusNoPre(input logic [4:0] phy, input logic [4:0] regad);
    exp_t e;
    int acc;
    @(negedge clk_50);
    b_cmd_valid    = 1'b1;
    b_cmd_write    = 1'b0;
    b_cmd_phy_addr = phy;
    b_cmd_reg_addr = regad;
    acc = -1;
    for (int t = 0; t < 2000; t++) begin
      if (b_cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk_50);
    end
    if (acc < 0) begin
      reportTimeout("nopre_cmd_accept");
    end else begin
      e.rdata     = 16'hFFFF;
      e.err       = 1'b1;
      e.cycle     = acc + 1 + FRAME0_CYC;
      e.wire_bits = 64'h0;
      e.oe_bits   = 64'h0;
      expb_q.push_back(e);
      @(negedge clk_50);
    end
    b_cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 3000; t++) begin
      if (exp_q.size() == 0 && expb_q.size() == 0) break;
      @(negedge clk_50);
    end
    if (exp_q.size() != 0 || expb_q.size() != 0) begin
      reportTimeout("rsp_valid");
      exp_q.delete();
      expb_q.delete();
    end
    repeat (4) @(negedge clk_50);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    checkOutput({tag, "_mdc"}, 64'(mdc), 64'd0);
    checkOutput({tag, "_mdio_o"}, 64'(mdio_o), 64'd1);
    checkOutput({tag, "_mdio_oe"}, 64'(mdio_oe), 64'd0);
  endtask

  // Hang guard: a runaway run is reported and stopped.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int acc_a;
    int acc_b;
    int highs;
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_phy_addr   = 5'h0;
    cmd_reg_addr   = 5'h0;
    cmd_wdata      = 16'h0;
    b_cmd_valid    = 1'b0;
    b_cmd_write    = 1'b0;
    b_cmd_phy_addr = 5'h0;
    b_cmd_reg_addr = 5'h0;
    b_cmd_wdata    = 16'h0;
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    repeat (5) @(negedge clk_50);

    $display("[TB] reset while idle");
    reset = 1'b1;
    repeat (3) @(negedge clk_50);
    checkResetValues("reset");
    checkOutput("reset_nopre_cmd_ready", 64'(b_cmd_ready), 64'd1);
    reset = 1'b0;
    highs = 0;
    repeat (20) begin
      @(negedge clk_50);
      if (mdc || b_mdc) highs++;
    end
    checkOutput("idle_mdc_static", 64'(highs), 64'd0);

    $display("[TB] write PHY 01 REG 00 data 1140");
    applyStimulus(1'b1, 5'h01, 5'h00, 16'h1140, {32'hFFFF_FFFF, 32'h5082_1140},
                  64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b1, 1'b0, acc_a);
    waitDrain();

    $display("[TB] read PHY 10 REG 02 with responder");
    phy_mode = 1'b1;
    phy_data = 16'h0141;
    applyStimulus(1'b0, 5'h10, 5'h02, 16'hDEAD, {32'hFFFF_FFFF, 14'b01101000000010, 18'h0},
                  64'hFFFF_FFFF_FFFC_0000, 16'h0141, 1'b0, 1'b1, 1'b0, acc_a);
    waitDrain();
    phy_mode = 1'b0;

    $display("[TB] read with no responder");
    applyStimulus(1'b0, 5'h1F, 5'h1F, 16'h0000, {32'hFFFF_FFFF, 14'b01101111111111, 18'h0},
                  64'hFFFF_FFFF_FFFC_0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, acc_a);
    waitDrain();

    $display("[TB] held cmd_valid, back-to-back writes");
    applyStimulus(1'b1, 5'h03, 5'h04, 16'hA5C3, {32'hFFFF_FFFF, 32'h5192_A5C3},
                  64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b1, 1'b1, acc_a);
    cmd_write    = 1'b1;
    cmd_phy_addr = 5'h1E;
    cmd_reg_addr = 5'h11;
    cmd_wdata    = 16'h3C0F;
    applyStimulus(1'b1, 5'h1E, 5'h11, 16'h3C0F, {32'hFFFF_FFFF, 32'h5F46_3C0F},
                  64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0, 1'b1, 1'b0, acc_b);
    checkOutput("b2b_accept_cycle", 64'(acc_b), 64'(acc_a + FRAME_CYC + 2));
    waitDrain();

    $display("[TB] reset during a write frame");
    applyStimulus(1'b1, 5'h07, 5'h09, 16'h1234, 64'h0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0, acc_a);
    for (int t = 0; t < 1000; t++) begin
      if (rises >= 41) break;
      @(negedge clk_50);
    end
    if (rises < 41) reportTimeout("reach_bit_40");
    reset = 1'b1;
    @(negedge clk_50);
    checkResetValues("midframe_reset");
    reset = 1'b0;
    repeat (600) @(negedge clk_50);
    checkOutput("after_abandon_busy", 64'(busy), 64'd0);

    $display("[TB] preamble-suppressed read");
    applyStimulusNoPre(5'h02, 5'h03);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
